// File: rtl/capa_transaccion_rr.sv
// Transaction layer: per-class virtual-channel queues feeding per-destination egress queues
// through a round-robin arbiter, with threshold flags and readable event counters.
module capa_transaccion_rr #(
  parameter int unsigned DW    = 12,
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 5,
  localparam int unsigned LN   = $clog2(N),
  localparam int unsigned AW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  input  logic [AW-1:0]   umbral_alto,
  input  logic [AW-1:0]   umbral_bajo,
  input  logic [DW-1:0]   data_in,
  input  logic            push,
  output logic            ready_in,
  input  logic [N-1:0]    pop,
  output logic [N*DW-1:0] data_out,
  output logic [N-1:0]    empty_out,
  output logic [N-1:0]    almost_empty_out,
  output logic [N-1:0]    almost_full_out,
  input  logic            req,
  input  logic [LN:0]     idx,
  output logic [CW-1:0]   cnt_data,
  output logic            cnt_valid,
  output logic            idle,
  output logic [1:0]      state
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [AW-1:0] FullOcc = AW'(DEPTH);
  localparam logic [LN:0]   IdxMax  = (LN + 1)'(N);

  typedef enum logic [1:0] {
    StReset  = 2'd0,
    StInit   = 2'd1,
    StIdle   = 2'd2,
    StActive = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] alto_q, bajo_q, alto_eff;

  // Virtual-channel queues, indexed by class
  logic [DW-1:0] vc_mem   [N][DEPTH];
  logic [PW-1:0] vc_wr_q  [N];
  logic [PW-1:0] vc_rd_q  [N];
  logic [AW-1:0] vc_occ_q [N];
  logic [DW-1:0] vc_head  [N];
  logic [LN-1:0] vc_dest  [N];
  logic [N-1:0]  vc_wr, vc_rd, vc_elig;

  // Egress queues, indexed by destination
  logic [DW-1:0] eg_mem   [N][DEPTH];
  logic [PW-1:0] eg_wr_q  [N];
  logic [PW-1:0] eg_rd_q  [N];
  logic [AW-1:0] eg_occ_q [N];
  logic [DW-1:0] eg_head  [N];
  logic [N-1:0]  eg_wr, eg_rd, eg_full;

  logic [CW-1:0] cnt_q [N+1];
  logic [CW-1:0] cnt_data_q;
  logic          cnt_valid_q;

  logic [LN-1:0] last_q, grant_idx, grant_dest, cand, in_class;
  logic          grant_valid, run, push_ok, any_busy;
  logic [DW-1:0] xfer_data;

  // Ingress acceptance
  always_comb begin
    run      = (state_q == StIdle) || (state_q == StActive);
    in_class = data_in[DW-1 -: LN];
    ready_in = run && (vc_occ_q[in_class] != FullOcc);
    push_ok  = push && ready_in;
  end

  // A registered threshold of zero means "almost full only when completely full"
  assign alto_eff = (alto_q == '0) ? FullOcc : alto_q;

  // Egress heads and flags
  always_comb begin
    data_out = '0;
    for (int j = 0; j < N; j++) begin
      eg_head[j]          = eg_mem[j][eg_rd_q[j]];
      empty_out[j]        = (eg_occ_q[j] == '0);
      eg_full[j]          = (eg_occ_q[j] == FullOcc);
      almost_full_out[j]  = (eg_occ_q[j] >= alto_eff);
      almost_empty_out[j] = (eg_occ_q[j] <= bajo_q);
      eg_rd[j]            = pop[j] && (eg_occ_q[j] != '0);
      data_out[j*DW +: DW] = empty_out[j] ? '0 : eg_head[j];
    end
  end

  // VC heads, writes and eligibility
  always_comb begin
    for (int i = 0; i < N; i++) begin
      vc_head[i] = vc_mem[i][vc_rd_q[i]];
      vc_dest[i] = vc_head[i][DW-1-LN -: LN];
      vc_wr[i]   = push_ok && (in_class == LN'(i));
      vc_elig[i] = run && (vc_occ_q[i] != '0) && !almost_full_out[vc_dest[i]] &&
                   !eg_full[vc_dest[i]];
    end
  end

  // Round-robin search starting just after the last granted VC
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= N; k++) begin
      cand = last_q + LN'(k);
      if (!grant_valid && vc_elig[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_dest = vc_dest[grant_idx];
    xfer_data  = vc_head[grant_idx];
    for (int i = 0; i < N; i++) begin
      vc_rd[i] = grant_valid && (grant_idx == LN'(i));
      eg_wr[i] = grant_valid && (grant_dest == LN'(i));
    end
  end

  always_comb begin
    any_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vc_occ_q[i] != '0 || eg_occ_q[i] != '0) begin
        any_busy = 1'b1;
      end
    end
  end

  // State machine
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset: state_d = StInit;
      StInit: begin
        if (!init) begin
          state_d = StIdle;
        end
      end
      StIdle, StActive: begin
        if (init) begin
          state_d = StInit;
        end else begin
          state_d = any_busy ? StActive : StIdle;
        end
      end
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StReset;
      alto_q  <= AW'(DEPTH - 1);
      bajo_q  <= AW'(1);
      last_q  <= LN'(N - 1);
    end else begin
      state_q <= state_d;
      if (state_q == StInit) begin
        alto_q <= umbral_alto;
        bajo_q <= umbral_bajo;
      end
      if (grant_valid) begin
        last_q <= grant_idx;
      end
    end
  end

  // Queue pointers and occupancies
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        vc_wr_q[i]  <= '0;
        vc_rd_q[i]  <= '0;
        vc_occ_q[i] <= '0;
        eg_wr_q[i]  <= '0;
        eg_rd_q[i]  <= '0;
        eg_occ_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vc_wr[i]) vc_wr_q[i] <= vc_wr_q[i] + 1'b1;
        if (vc_rd[i]) vc_rd_q[i] <= vc_rd_q[i] + 1'b1;
        case ({vc_wr[i], vc_rd[i]})
          2'b10:   vc_occ_q[i] <= vc_occ_q[i] + 1'b1;
          2'b01:   vc_occ_q[i] <= vc_occ_q[i] - 1'b1;
          default: vc_occ_q[i] <= vc_occ_q[i];
        endcase
        if (eg_wr[i]) eg_wr_q[i] <= eg_wr_q[i] + 1'b1;
        if (eg_rd[i]) eg_rd_q[i] <= eg_rd_q[i] + 1'b1;
        case ({eg_wr[i], eg_rd[i]})
          2'b10:   eg_occ_q[i] <= eg_occ_q[i] + 1'b1;
          2'b01:   eg_occ_q[i] <= eg_occ_q[i] - 1'b1;
          default: eg_occ_q[i] <= eg_occ_q[i];
        endcase
      end
    end
  end

  // Storage arrays; contents are meaningless once occupancy is cleared
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (vc_wr[i]) vc_mem[i][vc_wr_q[i]] <= data_in;
      if (eg_wr[i]) eg_mem[i][eg_wr_q[i]] <= xfer_data;
    end
  end

  // Event counters; a same-cycle read sees the pre-increment value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= N; i++) begin
        cnt_q[i] <= '0;
      end
      cnt_valid_q <= 1'b0;
      cnt_data_q  <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (eg_wr[j]) cnt_q[j] <= cnt_q[j] + 1'b1;
      end
      if (push_ok) cnt_q[N] <= cnt_q[N] + 1'b1;
      if (req && (idx <= IdxMax)) begin
        cnt_valid_q <= 1'b1;
        cnt_data_q  <= cnt_q[idx];
      end else begin
        cnt_valid_q <= 1'b0;
        cnt_data_q  <= '0;
      end
    end
  end

  assign cnt_valid = cnt_valid_q;
  assign cnt_data  = cnt_data_q;
  assign idle      = (state_q == StIdle);
  assign state     = state_q;

endmodule
